fp_div_result_buffer: RTL and testbench

- Sits directly downstream of the FP divider wrapper and captures each valid result, status and tag it produces.
- The divider has no backpressure (ready tied high), so this block holds results until the interconnect accepts them over a valid/ready handshake.
- It also tracks issue credits, so the upstream issuer never has more ops in flight plus buffered than DEPTH. An accepted result therefore can never be dropped.

---
 rtl/apu_cluster_package.sv | 22 ++
 rtl/fp_div_credit_cnt.sv | 48 ++++
 rtl/fp_div_result_buffer.sv | 134 +++++++++++++
 tb/tb_fp_div_result_buffer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/apu_cluster_package.sv
// Shared APU cluster definitions: FP widths, divider status width and the
// result-buffer depth/entry types used by fp_div_result_buffer.
package apu_cluster_package;

    localparam int unsigned FP_WIDTH          = 32;
    localparam int unsigned NUSFLAGS_DIV      = 5;
    localparam int unsigned FP_DIV_RB_DEPTH   = 4;
    localparam int unsigned FP_DIV_TAG_WIDTH  = 1;

    // One buffered divider result at the cluster's default widths
    typedef struct packed {
        logic [FP_WIDTH-1:0]         res;
        logic [NUSFLAGS_DIV-1:0]     status;
        logic [FP_DIV_TAG_WIDTH-1:0] tag;
    } fp_div_res_t;

    // Pointer width for a DEPTH-entry circular buffer, never below one bit
    function automatic int unsigned fp_div_ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fp_div_credit_cnt.sv
// Up/down issue-credit counter starting at DEPTH. Decrements on an issue
// while credits remain, increments on a returned result, and flags an issue
// attempted with no credit instead of underflowing.
module fp_div_credit_cnt
    import apu_cluster_package::*;
#(
    parameter int unsigned DEPTH = FP_DIV_RB_DEPTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc,
    input  logic dec,
    output logic avail,
    output logic err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0] credits;
    logic [CW-1:0] credits_next;
    logic          dec_ok;

    assign avail = (credits != '0);
    assign err   = dec && (credits == '0);

    // Next credit value: simultaneous issue and return cancel out; saturate at both ends
    always_comb begin
        credits_next = credits;
        dec_ok       = dec && (credits != '0);
        if (inc && !dec_ok) begin
            if (credits != CW'(DEPTH)) begin
                credits_next = credits + CW'(1);
            end
        end else if (!inc && dec_ok) begin
            credits_next = credits - CW'(1);
        end
    end

    // Credit register, full credit on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits <= CW'(DEPTH);
        end else begin
            credits <= credits_next;
        end
    end

endmodule

// File: rtl/fp_div_result_buffer.sv
// Result buffer behind the FP divider: captures every valid result/status/tag,
// holds it until the interconnect takes it over valid/ready, and meters issue
// credits so an accepted result is never dropped.
// Optional macro FP_DIV_RESULT_BYPASS_EN: when empty, a divider result is
// presented on the outputs in the same cycle it arrives.
module fp_div_result_buffer
    import apu_cluster_package::*;
#(
    parameter int unsigned DEPTH      = FP_DIV_RB_DEPTH,
    parameter int unsigned TAG_WIDTH  = 1,
    parameter int unsigned STAT_WIDTH = NUSFLAGS_DIV
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  Issue_i,
    output logic                  IssueReady_o,
    input  logic                  DivValid_i,
    input  logic [FP_WIDTH-1:0]   DivRes_i,
    input  logic [STAT_WIDTH-1:0] DivStatus_i,
    input  logic [TAG_WIDTH-1:0]  DivTag_i,
    output logic                  Valid_o,
    input  logic                  Ready_i,
    output logic [FP_WIDTH-1:0]   Res_o,
    output logic [STAT_WIDTH-1:0] Status_o,
    output logic [TAG_WIDTH-1:0]  Tag_o,
    output logic                  Err_o
);

    localparam int unsigned PW = fp_div_ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [FP_WIDTH-1:0]   res;
        logic [STAT_WIDTH-1:0] status;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        incoming;
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          consume;
    logic          drop;
    logic          credit_err;
    logic          err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign incoming = '{res: DivRes_i, status: DivStatus_i, tag: DivTag_i};
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    // Handshake decode; a bypassed result taken the same cycle never occupies an entry
    always_comb begin
`ifdef FP_DIV_RESULT_BYPASS_EN
        bypass = empty && DivValid_i;
`else
        bypass = 1'b0;
`endif
        Valid_o = !empty || bypass;
        consume = Valid_o && Ready_i;
        pop     = !empty && Ready_i;
        push    = DivValid_i && !full && !(bypass && Ready_i);
        drop    = DivValid_i && full;
        head    = bypass ? incoming : mem[rd_ptr];
    end

    assign Res_o    = head.res;
    assign Status_o = head.status;
    assign Tag_o    = head.tag;
    assign Err_o    = err;

    // Entry storage, cleared on reset so an idle buffer presents zeros
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= incoming;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky protocol-violation flag: dropped result or issue without credit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err <= 1'b0;
        end else if (drop || credit_err) begin
            err <= 1'b1;
        end
    end

    fp_div_credit_cnt #(
        .DEPTH (DEPTH)
    ) u_credit_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (consume),
        .dec    (Issue_i),
        .avail  (IssueReady_o),
        .err    (credit_err)
    );

endmodule

// File: tb/tb_fp_div_result_buffer.sv
// Directed bench for fp_div_result_buffer with a scoreboard queue and a small
// occupancy/credit model. Build with +define+FP_DIV_RESULT_BYPASS_EN to cover
// the same-cycle bypass path.
module tb_fp_div_result_buffer;
    import apu_cluster_package::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 2;
    localparam int unsigned SW    = NUSFLAGS_DIV;

    typedef struct packed {
        logic [FP_WIDTH-1:0] res;
        logic [SW-1:0]       st;
        logic [TW-1:0]       tag;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                issue = 1'b0;
    logic                issue_ready;
    logic                div_valid = 1'b0;
    logic [FP_WIDTH-1:0] div_res = '0;
    logic [SW-1:0]       div_status = '0;
    logic [TW-1:0]       div_tag = '0;
    logic                valid;
    logic                ready = 1'b0;
    logic [FP_WIDTH-1:0] res;
    logic [SW-1:0]       status;
    logic [TW-1:0]       tag;
    logic                err;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;
    int   m_cred = DEPTH;
    logic m_err = 1'b0;

    always #5 clk = ~clk;

    fp_div_result_buffer #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TW),
        .STAT_WIDTH (SW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .Issue_i      (issue),
        .IssueReady_o (issue_ready),
        .DivValid_i   (div_valid),
        .DivRes_i     (div_res),
        .DivStatus_i  (div_status),
        .DivTag_i     (div_tag),
        .Valid_o      (valid),
        .Ready_i      (ready),
        .Res_o        (res),
        .Status_o     (status),
        .Tag_o        (tag),
        .Err_o        (err)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check at negedge against the model, advance the model
    task automatic cycle(input logic iss, input logic dv, input logic [FP_WIDTH-1:0] r,
                         input logic [SW-1:0] st, input logic [TW-1:0] tg, input logic rdy);
        logic exp_valid, take, bypass_hit, pop_buf, push_buf, issue_ok;
        exp_t e;
        issue = iss; div_valid = dv; div_res = r; div_status = st; div_tag = tg; ready = rdy;
        @(negedge clk);
        bypass_hit = 1'b0;
`ifdef FP_DIV_RESULT_BYPASS_EN
        bypass_hit = (m_cnt == 0) && dv;
`endif
        exp_valid = (m_cnt != 0) || bypass_hit;
        take      = dv && (m_cnt < DEPTH);
        chk("valid", 64'(valid), 64'(exp_valid));
        chk("issue_ready", 64'(issue_ready), 64'(m_cred != 0));
        chk("err", 64'(err), 64'(m_err));
        if (take) begin
            e = {r, st, tg};
            sb.push_back(e);
        end
        if (exp_valid) begin
            e = sb[0];
            chk("res", 64'(res), 64'(e.res));
            chk("status", 64'(status), 64'(e.st));
            chk("tag", 64'(tag), 64'(e.tag));
            if (rdy) void'(sb.pop_front());
        end
        pop_buf  = rdy && (m_cnt != 0);
        push_buf = take && !(bypass_hit && rdy);
        issue_ok = iss && (m_cred != 0);
        if (iss && m_cred == 0) m_err = 1'b1;
        if (dv && !take) m_err = 1'b1;
        m_cnt  = m_cnt + int'(push_buf) - int'(pop_buf);
        m_cred = m_cred - int'(issue_ok) + int'(exp_valid && rdy);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset applied off the clock edge; outputs must clear at once
    task automatic do_reset(input string name);
        issue = 1'b0; div_valid = 1'b0; ready = 1'b0;
        div_res = '0; div_status = '0; div_tag = '0;
        rst_n = 1'b0;
        #1;
        chk({name, "_valid"}, 64'(valid), 64'd0);
        chk({name, "_issue_ready"}, 64'(issue_ready), 64'd1);
        chk({name, "_err"}, 64'(err), 64'd0);
        chk({name, "_res"}, 64'(res), 64'd0);
        chk({name, "_status"}, 64'(status), 64'd0);
        chk({name, "_tag"}, 64'(tag), 64'd0);
        sb.delete();
        m_cnt = 0; m_cred = DEPTH; m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        do_reset("reset");

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
            chk("idle_res", 64'(res), 64'd0);
        end

        // Single op, one cycle of backpressure, then drain
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'h3FC0_0000, 5'h01, 2'd1, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Fill under backpressure, hold, then drain in order
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 32'h4000_0000 + 32'(i), 5'(i + 2), 2'(i), 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Steady issue/push/pop every cycle across several pointer wraps
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b1, 32'h1234_0000 ^ 32'(i * 7), 5'(i), 2'(i), 1'b1);
        cycle(1'b0, 1'b1, 32'hCAFE_0001, 5'h1F, 2'd3, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Overflow: a fifth result with four held is dropped and flags an error
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 32'h5000_0000 + 32'(i), 5'(i + 9), 2'(i), 1'b0);
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 5'h1E, 2'd3, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Async reset mid-drain with three entries held
        ready = 1'b1;
        #3;
        chk("pre_reset_valid", 64'(valid), 64'd1);
        do_reset("mid_reset");

        // Issue without credit: error, no underflow
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 32'h6000_0000 + 32'(i), 5'(i), 2'(i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Empty buffer, result arrives while the interconnect is ready
        do_reset("reset2");
        cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'h7F80_0000, 5'h04, 2'd2, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
